// File: rtl/iddr_loopback_checker.sv
// IDDR loopback self-test: pulses the IDDR reset, waits for PLL lock and settling, learns a Q1/Q2 pattern, then checks it.
// Optional define IDDR_CHK_FIRST_ERR_EN adds first_err_idx_o / first_err_pair_o capture of the first CHECK mismatch.

module iddr_loopback_checker #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int PAT_LEN       = 6,
    parameter int WINDOW        = 1024,
    parameter int ERR_W         = 16,
    localparam int IDX_W        = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             locked_i,
    input  logic             q1_i,
    input  logic             q2_i,
    output logic             iddr_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             lock_lost_o,
    output logic [ERR_W-1:0] err_count_o
`ifdef IDDR_CHK_FIRST_ERR_EN
    ,
    output logic [IDX_W-1:0] first_err_idx_o,
    output logic [1:0]       first_err_pair_o
`endif
);

    localparam int CNT_MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > WINDOW) ? CNT_MAX_A : WINDOW;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int KW        = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW - 1);
    localparam logic [KW-1:0]    PAT_LAST    = KW'(PAT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOCK,
        S_IDDR_RST,
        S_SETTLE,
        S_LEARN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [KW-1:0]    k_q;
    logic [1:0]       pat_q [PAT_LEN];

    logic [1:0]       pair_d;
    logic             mismatch_d;
    logic [ERR_W-1:0] err_inc_d;
    logic [KW-1:0]    k_next_d;
    logic             lock_lost_d;

`ifdef IDDR_CHK_FIRST_ERR_EN
    logic             first_err_seen_q;
`endif

    always_comb begin
        pair_d      = {q1_i, q2_i};
        mismatch_d  = (pair_d != pat_q[k_q]);
        err_inc_d   = (&err_count_o) ? err_count_o : err_count_o + ERR_W'(1);
        k_next_d    = (k_q == PAT_LAST) ? '0 : k_q + KW'(1);
        lock_lost_d = !locked_i && ((state_q == S_IDDR_RST) || (state_q == S_SETTLE) ||
                                    (state_q == S_LEARN) || (state_q == S_CHECK));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            for (int i = 0; i < PAT_LEN; i++) pat_q[i] <= '0;
            iddr_rst_o  <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            lock_lost_o <= 1'b0;
            err_count_o <= '0;
`ifdef IDDR_CHK_FIRST_ERR_EN
            first_err_seen_q <= 1'b0;
            first_err_idx_o  <= '0;
            first_err_pair_o <= '0;
`endif
        end else if (lock_lost_d) begin
            // abort keeps err_count as accumulated; the aborting cycle is not compared
            state_q     <= S_DONE;
            iddr_rst_o  <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            pass_o      <= 1'b0;
            lock_lost_o <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    iddr_rst_o <= 1'b1;
                    if (start_i) begin
                        state_q     <= S_WAIT_LOCK;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        lock_lost_o <= 1'b0;
                        err_count_o <= '0;
`ifdef IDDR_CHK_FIRST_ERR_EN
                        first_err_seen_q <= 1'b0;
                        first_err_idx_o  <= '0;
                        first_err_pair_o <= '0;
`endif
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_i) begin
                        state_q <= S_IDDR_RST;
                        cnt_q   <= '0;
                    end
                end
                S_IDDR_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q    <= S_SETTLE;
                        iddr_rst_o <= 1'b0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= S_LEARN;
                        k_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_LEARN: begin
                    pat_q[k_q] <= pair_d;
                    k_q        <= k_next_d;
                    if (k_q == PAT_LAST) begin
                        state_q <= S_CHECK;
                        cnt_q   <= '0;
                    end
                end
                S_CHECK: begin
                    k_q <= k_next_d;
                    if (mismatch_d) begin
                        err_count_o <= err_inc_d;
`ifdef IDDR_CHK_FIRST_ERR_EN
                        if (!first_err_seen_q) begin
                            first_err_seen_q <= 1'b1;
                            first_err_idx_o  <= IDX_W'(cnt_q);
                            first_err_pair_o <= pair_d;
                        end
`endif
                    end
                    if (cnt_q == WIN_LAST) begin
                        state_q    <= S_DONE;
                        iddr_rst_o <= 1'b1;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        pass_o     <= (err_count_o == '0) && !mismatch_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iddr_loopback_checker.sv
// Testbench for iddr_loopback_checker: randomized Q1/Q2 streams checked against a phase-timeline reference model.
// Build with IDDR_CHK_FIRST_ERR_EN defined to also check the first-error capture outputs.

module tb_iddr_loopback_checker;

    localparam int R  = 16, S  = 64, P  = 6, W  = 1024;
    localparam int R4 = 3,  S4 = 5,  P4 = 3, W4 = 40;
    localparam int MAXT = 1400;

    logic clk = 1'b0;
    logic rst, start, locked, q1, q2;

    logic irst, busy, done, pass, ll;
    logic [15:0] err;
    logic irst4, busy4, done4, pass4, ll4;
    logic [3:0] err4;
`ifdef IDDR_CHK_FIRST_ERR_EN
    logic [9:0] fidx;
    logic [1:0] fpair;
    logic [5:0] fidx4;
    logic [1:0] fpair4;
`endif

    always #5 clk = ~clk;

    iddr_loopback_checker dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .locked_i(locked), .q1_i(q1), .q2_i(q2),
        .iddr_rst_o(irst), .busy_o(busy), .done_o(done), .pass_o(pass), .lock_lost_o(ll),
        .err_count_o(err)
`ifdef IDDR_CHK_FIRST_ERR_EN
        , .first_err_idx_o(fidx), .first_err_pair_o(fpair)
`endif
    );

    iddr_loopback_checker #(
        .RST_CYCLES(R4), .SETTLE_CYCLES(S4), .PAT_LEN(P4), .WINDOW(W4), .ERR_W(4)
    ) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .locked_i(locked), .q1_i(q1), .q2_i(q2),
        .iddr_rst_o(irst4), .busy_o(busy4), .done_o(done4), .pass_o(pass4), .lock_lost_o(ll4),
        .err_count_o(err4)
`ifdef IDDR_CHK_FIRST_ERR_EN
        , .first_err_idx_o(fidx4), .first_err_pair_o(fpair4)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [1:0] stim_p     [MAXT];
    logic       stim_lock  [MAXT];
    logic       stim_start [MAXT];
    logic [1:0] base       [8];

    int x_done, x_fall, x_err, x_fidx;
    bit x_pass, x_ll;
    logic [1:0] x_fpair;
    int o_done, o_fall, o_bdrop, o_err, o_fidx;
    bit o_pass, o_ll;
    logic [1:0] o_fpair;

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; locked = 1'b1; q1 = 1'b0; q2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXT; i++) begin
            stim_p[i] = 2'b00; stim_lock[i] = 1'b1; stim_start[i] = 1'b0;
        end
        stim_start[0] = 1'b1;
    endtask

    task automatic fill_pattern(input int plen, input int phase);
        for (int i = 0; i < MAXT; i++) stim_p[i] = base[(i + phase) % plen];
    endtask

    // Edge 0 is the edge that samples start. Phases follow from the first locked edge w.
    task automatic model_run(input int rc, input int sc, input int pl, input int wn, input int emax,
                             output int e_done, output int e_fall, output int e_err,
                             output bit e_pass, output bit e_ll, output int e_fidx,
                             output logic [1:0] e_fpair);
        int w, l0, c0, cend, mism;
        logic [1:0] pat [8];
        w = 1;
        while (w < MAXT - 1 && stim_lock[w] !== 1'b1) w++;
        l0 = w + rc + sc + 1;
        c0 = l0 + pl;
        cend = c0 + wn - 1;
        e_done = cend; e_ll = 1'b0; e_fidx = 0; e_fpair = 2'b00; mism = 0;
        for (int e = w + 1; e <= cend && e < MAXT; e++) begin
            if (stim_lock[e] !== 1'b1) begin
                e_done = e; e_ll = 1'b1; break;
            end
        end
        e_fall = (e_ll && e_done <= w + rc) ? -1 : w + rc;
        for (int i = 0; i < pl; i++) pat[i] = stim_p[l0 + i];
        for (int e = c0; e <= cend && e < MAXT; e++) begin
            if (e_ll && e >= e_done) break;
            if (stim_p[e] != pat[(e - c0) % pl]) begin
                if (mism == 0) begin
                    e_fidx = e - c0; e_fpair = stim_p[e];
                end
                mism++;
            end
        end
        e_err = (mism > emax) ? emax : mism;
        e_pass = !e_ll && (mism == 0);
    endtask

    task automatic drive_run(input bit sel, input int maxcyc,
                             output int d_edge, output int f_edge, output int b_edge,
                             output int r_err, output bit r_pass, output bit r_ll,
                             output int r_fidx, output logic [1:0] r_fpair);
        d_edge = -1; f_edge = -1; b_edge = -1;
        for (int e = 0; e < maxcyc && e < MAXT; e++) begin
            start = stim_start[e]; locked = stim_lock[e]; {q1, q2} = stim_p[e];
            @(posedge clk);
            #1;
            if (f_edge < 0 && !(sel ? irst4 : irst)) f_edge = e;
            if (b_edge < 0 && !(sel ? busy4 : busy)) b_edge = e;
            if (sel ? done4 : done) begin
                d_edge = e; break;
            end
        end
        start = 1'b0;
        r_err  = sel ? int'(err4) : int'(err);
        r_pass = sel ? pass4 : pass;
        r_ll   = sel ? ll4 : ll;
        r_fidx = 0; r_fpair = 2'b00;
`ifdef IDDR_CHK_FIRST_ERR_EN
        r_fidx  = sel ? int'(fidx4) : int'(fidx);
        r_fpair = sel ? fpair4 : fpair;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; locked = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (irst !== 1'b1) begin failures++; $display("FAIL rst_iddr_rst got=%b exp=1", irst); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        if (pass !== 1'b0) begin failures++; $display("FAIL rst_pass got=%b exp=0", pass); end
        if (ll !== 1'b0) begin failures++; $display("FAIL rst_lock_lost got=%b exp=0", ll); end
        if (err !== 16'd0) begin failures++; $display("FAIL rst_err got=%0d exp=0", err); end
        if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy4 got=%b exp=0", busy4); end
`ifdef IDDR_CHK_FIRST_ERR_EN
        checks += 2;
        if (fidx !== 10'd0) begin failures++; $display("FAIL rst_fidx got=%0d exp=0", fidx); end
        if (fpair !== 2'd0) begin failures++; $display("FAIL rst_fpair got=%0d exp=0", fpair); end
`endif
        start = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start got=%b exp=0", busy); end
    endtask

    task automatic test_clean_pattern();
        apply_reset(); clear_stim();
        base[0] = 2'b10; base[1] = 2'b01; base[2] = 2'b11;
        fill_pattern(3, 0);
        model_run(R, S, P, W, 65535, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
        drive_run(1'b0, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
        checks += 6;
        if (o_done !== x_done) begin failures++; $display("FAIL clean_done_edge got=%0d exp=%0d", o_done, x_done); end
        if (o_fall !== x_fall) begin failures++; $display("FAIL clean_iddr_fall got=%0d exp=%0d", o_fall, x_fall); end
        if (o_bdrop !== x_done) begin failures++; $display("FAIL clean_busy_drop got=%0d exp=%0d", o_bdrop, x_done); end
        if (o_err !== x_err) begin failures++; $display("FAIL clean_err got=%0d exp=%0d", o_err, x_err); end
        if (o_pass !== x_pass) begin failures++; $display("FAIL clean_pass got=%b exp=%b", o_pass, x_pass); end
        if (o_ll !== x_ll) begin failures++; $display("FAIL clean_lock_lost got=%b exp=%b", o_ll, x_ll); end
    endtask

    task automatic test_single_flip();
        int c0;
        apply_reset(); clear_stim();
        base[0] = 2'b10; base[1] = 2'b01; base[2] = 2'b11;
        fill_pattern(3, 0);
        c0 = 1 + R + S + 1 + P;
        stim_p[c0 + 100] = ~stim_p[c0 + 100];
        model_run(R, S, P, W, 65535, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
        drive_run(1'b0, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
        checks += 3;
        if (o_done !== x_done) begin failures++; $display("FAIL flip_done_edge got=%0d exp=%0d", o_done, x_done); end
        if (o_err !== x_err) begin failures++; $display("FAIL flip_err got=%0d exp=%0d", o_err, x_err); end
        if (o_pass !== x_pass) begin failures++; $display("FAIL flip_pass got=%b exp=%b", o_pass, x_pass); end
`ifdef IDDR_CHK_FIRST_ERR_EN
        checks += 2;
        if (o_fidx !== x_fidx) begin failures++; $display("FAIL flip_fidx got=%0d exp=%0d", o_fidx, x_fidx); end
        if (o_fpair !== x_fpair) begin failures++; $display("FAIL flip_fpair got=%0d exp=%0d", o_fpair, x_fpair); end
`endif
    endtask

    task automatic test_lock_wait();
        apply_reset(); clear_stim();
        base[0] = 2'b10; base[1] = 2'b01; base[2] = 2'b11;
        fill_pattern(3, 1);
        for (int i = 0; i < 50; i++) stim_lock[i] = 1'b0;
        model_run(R, S, P, W, 65535, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
        drive_run(1'b0, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
        checks += 4;
        if (o_fall !== x_fall) begin failures++; $display("FAIL wait_iddr_fall got=%0d exp=%0d", o_fall, x_fall); end
        if (o_done !== x_done) begin failures++; $display("FAIL wait_done_edge got=%0d exp=%0d", o_done, x_done); end
        if (o_pass !== x_pass) begin failures++; $display("FAIL wait_pass got=%b exp=%b", o_pass, x_pass); end
        if (o_ll !== x_ll) begin failures++; $display("FAIL wait_lock_lost got=%b exp=%b", o_ll, x_ll); end
    endtask

    task automatic test_lock_drop();
        int c0, de;
        apply_reset(); clear_stim();
        base[0] = 2'b10; base[1] = 2'b01; base[2] = 2'b11;
        fill_pattern(3, 0);
        c0 = 1 + R + S + 1 + P;
        stim_p[c0 + 3] = ~stim_p[c0 + 3];
        for (int i = c0 + 10; i < MAXT; i++) stim_lock[i] = 1'b0;
        model_run(R, S, P, W, 65535, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
        drive_run(1'b0, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
        checks += 5;
        if (o_done !== x_done) begin failures++; $display("FAIL drop_done_edge got=%0d exp=%0d", o_done, x_done); end
        if (o_ll !== x_ll) begin failures++; $display("FAIL drop_lock_lost got=%b exp=%b", o_ll, x_ll); end
        if (o_pass !== x_pass) begin failures++; $display("FAIL drop_pass got=%b exp=%b", o_pass, x_pass); end
        if (o_err !== x_err) begin failures++; $display("FAIL drop_err got=%0d exp=%0d", o_err, x_err); end
        if (o_bdrop !== x_done) begin failures++; $display("FAIL drop_busy_drop got=%0d exp=%0d", o_bdrop, x_done); end

        apply_reset(); clear_stim();
        fill_pattern(3, 2);
        de = $urandom_range(2, c0 - 1);
        for (int i = de; i < MAXT; i++) stim_lock[i] = 1'b0;
        model_run(R, S, P, W, 65535, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
        drive_run(1'b0, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
        checks += 3;
        if (o_done !== x_done) begin failures++; $display("FAIL early_drop_done_edge at=%0d got=%0d exp=%0d", de, o_done, x_done); end
        if (o_ll !== x_ll) begin failures++; $display("FAIL early_drop_lock_lost got=%b exp=%b", o_ll, x_ll); end
        if (o_fall !== x_fall) begin failures++; $display("FAIL early_drop_iddr_fall got=%0d exp=%0d", o_fall, x_fall); end
    endtask

    task automatic test_random();
        int d, c0, nflip, idx;
        for (int it = 0; it < 3; it++) begin
            apply_reset(); clear_stim();
            for (int i = 0; i < P; i++) base[i] = 2'($urandom_range(0, 3));
            fill_pattern(P, $urandom_range(0, P - 1));
            d = $urandom_range(0, 20);
            for (int i = 1; i <= d; i++) stim_lock[i] = 1'b0;
            c0 = d + 1 + R + S + 1 + P;
            if ($urandom_range(0, 3) == 0) stim_p[c0 - 1] = ~stim_p[c0 - 1];
            nflip = $urandom_range(0, 4);
            for (int f = 0; f < nflip; f++) begin
                idx = c0 + $urandom_range(0, W - 1);
                stim_p[idx] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 2) == 0)
                for (int i = d + 2 + $urandom_range(0, c0 + W - d - 3); i < MAXT; i++) stim_lock[i] = 1'b0;
            model_run(R, S, P, W, 65535, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
            drive_run(1'b0, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
            checks += 6;
            if (o_done !== x_done) begin failures++; $display("FAIL rand%0d_done_edge got=%0d exp=%0d", it, o_done, x_done); end
            if (o_fall !== x_fall) begin failures++; $display("FAIL rand%0d_iddr_fall got=%0d exp=%0d", it, o_fall, x_fall); end
            if (o_err !== x_err) begin failures++; $display("FAIL rand%0d_err got=%0d exp=%0d", it, o_err, x_err); end
            if (o_pass !== x_pass) begin failures++; $display("FAIL rand%0d_pass got=%b exp=%b", it, o_pass, x_pass); end
            if (o_ll !== x_ll) begin failures++; $display("FAIL rand%0d_lock_lost got=%b exp=%b", it, o_ll, x_ll); end
            if (o_bdrop !== x_done) begin failures++; $display("FAIL rand%0d_busy_drop got=%0d exp=%0d", it, o_bdrop, x_done); end
`ifdef IDDR_CHK_FIRST_ERR_EN
            checks += 2;
            if (o_fidx !== x_fidx) begin failures++; $display("FAIL rand%0d_fidx got=%0d exp=%0d", it, o_fidx, x_fidx); end
            if (o_fpair !== x_fpair) begin failures++; $display("FAIL rand%0d_fpair got=%0d exp=%0d", it, o_fpair, x_fpair); end
`endif
        end
    endtask

    task automatic test_saturate();
        int c0;
        apply_reset(); clear_stim();
        for (int i = 0; i < P4; i++) base[i] = 2'($urandom_range(0, 3));
        fill_pattern(P4, 0);
        c0 = 1 + R4 + S4 + 1 + P4;
        for (int e = c0; e < c0 + W4; e++) stim_p[e] = ~stim_p[e];
        model_run(R4, S4, P4, W4, 15, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
        drive_run(1'b1, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
        checks += 4;
        if (o_done !== x_done) begin failures++; $display("FAIL sat_done_edge got=%0d exp=%0d", o_done, x_done); end
        if (o_err !== x_err) begin failures++; $display("FAIL sat_err got=%0d exp=%0d", o_err, x_err); end
        if (o_pass !== x_pass) begin failures++; $display("FAIL sat_pass got=%b exp=%b", o_pass, x_pass); end
        if (o_ll !== x_ll) begin failures++; $display("FAIL sat_lock_lost got=%b exp=%b", o_ll, x_ll); end
    endtask

    task automatic test_rst_midrun();
        apply_reset(); clear_stim();
        base[0] = 2'b10; base[1] = 2'b01; base[2] = 2'b11;
        fill_pattern(3, 0);
        for (int e = 0; e <= R + 10; e++) begin
            start = stim_start[e]; locked = stim_lock[e]; {q1, q2} = stim_p[e];
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks += 2;
        if (irst !== 1'b0) begin failures++; $display("FAIL settle_iddr_rst got=%b exp=0", irst); end
        if (busy !== 1'b1) begin failures++; $display("FAIL settle_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 3;
        if (irst !== 1'b1) begin failures++; $display("FAIL midrst_iddr_rst got=%b exp=1", irst); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_stays_idle got=%b exp=0", busy); end
    endtask

    task automatic test_start_while_busy();
        int c0;
        apply_reset(); clear_stim();
        base[0] = 2'b10; base[1] = 2'b01; base[2] = 2'b11;
        fill_pattern(3, 0);
        c0 = 1 + R + S + 1 + P;
        stim_p[c0 + 7] = ~stim_p[c0 + 7];
        stim_start[R - 5] = 1'b1;
        stim_start[c0 + 20] = 1'b1;
        model_run(R, S, P, W, 65535, x_done, x_fall, x_err, x_pass, x_ll, x_fidx, x_fpair);
        drive_run(1'b0, x_done + 20, o_done, o_fall, o_bdrop, o_err, o_pass, o_ll, o_fidx, o_fpair);
        checks += 3;
        if (o_done !== x_done) begin failures++; $display("FAIL busy_start_done_edge got=%0d exp=%0d", o_done, x_done); end
        if (o_err !== x_err) begin failures++; $display("FAIL busy_start_err got=%0d exp=%0d", o_err, x_err); end
        if (o_pass !== x_pass) begin failures++; $display("FAIL busy_start_pass got=%b exp=%b", o_pass, x_pass); end
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (done !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", done); end
        if (int'(err) !== x_err) begin failures++; $display("FAIL hold_err got=%0d exp=%0d", err, x_err); end
        if (irst !== 1'b1) begin failures++; $display("FAIL hold_iddr_rst got=%b exp=1", irst); end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks += 3;
        if (done !== 1'b0) begin failures++; $display("FAIL restart_done got=%b exp=0", done); end
        if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
        if (err !== 16'd0) begin failures++; $display("FAIL restart_err got=%0d exp=0", err); end
`ifdef IDDR_CHK_FIRST_ERR_EN
        checks++;
        if (fidx !== 10'd0) begin failures++; $display("FAIL restart_fidx got=%0d exp=0", fidx); end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; locked = 1'b1; q1 = 1'b0; q2 = 1'b0;
        test_reset();
        test_clean_pattern();
        test_single_flip();
        test_lock_wait();
        test_lock_drop();
        test_random();
        test_saturate();
        test_rst_midrun();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
